// File: rtl/keypad_pkg.sv
// keypad_pkg: shared states, keymap and widths for the keypad entry scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
  localparam int ENTRY_W = 16;
  localparam int NIBBLE_W = 4;
  localparam logic [3:0] COL_INIT = 4'b1110;
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
  function automatic logic [NIBBLE_W-1:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [5:0] idx;
    idx = {row, col, 2'b00};
    return KEYMAP[idx +: NIBBLE_W];
  endfunction
endpackage

// File: rtl/keypad_col_scanner.sv
// keypad_col_scanner: column dwell timer, one-hot-low column drive and row sample strobe
module keypad_col_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DELAY = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  output logic [3:0] col_out,
  output logic [1:0] col_idx,
  output logic       strobe
);
  localparam int CW = SCAN_DELAY > 1 ? $clog2(SCAN_DELAY) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DELAY - 1);
  logic [CW-1:0] dwell_q, dwell_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] col_q, col_d;
  always_comb begin
    strobe = dwell_q == LAST;
    dwell_d = strobe ? '0 : dwell_q + 1'b1;
    idx_d = (strobe && !hold) ? idx_q + 2'd1 : idx_q;
    col_d = (strobe && !hold) ? {col_q[2:0], col_q[3]} : col_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_q <= '0;
      idx_q <= '0;
      col_q <= COL_INIT;
    end else begin
      dwell_q <= dwell_d;
      idx_q <= idx_d;
      col_q <= col_d;
    end
  end
  assign col_out = col_q;
  assign col_idx = idx_q;
endmodule

// File: rtl/keypad_entry_scan.sv
// keypad_entry_scan: 4x4 keypad scan/debounce into a hex entry register with valid/ready commit; KEYPAD_AUTOREPEAT_EN adds auto-repeat
module keypad_entry_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DELAY = 1024,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_SAMPLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  input  logic        enter,
  input  logic        value_ready,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] entry,
  output logic [15:0] value_out,
  output logic        value_valid
);
  // one width serves both the debounce and the repeat sample counters
  localparam int CMAX = DEBOUNCE_CNT > REPEAT_SAMPLES ? DEBOUNCE_CNT : REPEAT_SAMPLES;
  localparam int CNW = $clog2(CMAX + 1);
  localparam logic [CNW-1:0] DB_LAST = CNW'(DEBOUNCE_CNT - 1);
  logic [3:0] row_s1_q, row_s2_q, rn;
  logic en_s1_q, en_s2_q, en_prev_q;
  state_t st_q, st_d;
  logic [1:0] row_q, row_d, col_q, col_d, col_idx, enc;
  logic [CNW-1:0] cnt_q, cnt_d;
  logic hold, strobe, acc, rep_fire, commit;
  logic key_valid_q, key_valid_d;
  logic [NIBBLE_W-1:0] key_code_q, key_code_d;
  logic [ENTRY_W-1:0] entry_q, entry_d, value_out_q, value_out_d;
  logic value_valid_q, value_valid_d;
  keypad_col_scanner #(.SCAN_DELAY(SCAN_DELAY)) u_scan (
    .clk(clk), .rst(rst), .hold(hold), .col_out(col_out), .col_idx(col_idx), .strobe(strobe)
  );
  always_comb begin
    rn = ~row_s2_q;
    enc = {rn[3] | rn[2], rn[3] | rn[1]};
    st_d = st_q;
    row_d = row_q;
    col_d = col_q;
    cnt_d = cnt_q;
    acc = 1'b0;
    hold = 1'b1;
    if (strobe) begin
      case (st_q)
        SCAN: begin
          if ($onehot(rn)) begin
            row_d = enc;
            col_d = col_idx;
            acc = DEBOUNCE_CNT == 1;
            st_d = acc ? HELD : DEBOUNCE;
            cnt_d = acc ? '0 : CNW'(1);
          end else hold = 1'b0;
        end
        DEBOUNCE: begin
          if (row_s2_q == ~(4'b0001 << row_q)) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == DB_LAST) begin
              acc = 1'b1;
              st_d = HELD;
              cnt_d = '0;
            end
          end else begin
            st_d = SCAN;
            hold = 1'b0;
          end
        end
        HELD: begin
          acc = rep_fire;
          cnt_d = &row_s2_q ? cnt_q + 1'b1 : '0;
          if (&row_s2_q && cnt_q == DB_LAST) begin
            st_d = SCAN;
            cnt_d = '0;
            hold = 1'b0;
          end
        end
        default: st_d = SCAN;
      endcase
    end
  end
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CNW-1:0] RP_LAST = CNW'(REPEAT_SAMPLES - 1);
  logic [CNW-1:0] rep_q, rep_d;
  logic same_low;
  always_comb begin
    same_low = st_q == HELD && !row_s2_q[row_q];
    rep_fire = strobe && same_low && rep_q == RP_LAST;
    rep_d = st_q != HELD ? '0 : !strobe ? rep_q : (!same_low || rep_fire) ? '0 : rep_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rep_q <= '0;
    else rep_q <= rep_d;
  end
`else
  assign rep_fire = 1'b0;
`endif
  always_comb begin
    commit = en_s2_q & ~en_prev_q & ~value_valid_q;
    key_valid_d = acc;
    key_code_d = acc ? keymap(row_d, col_d) : key_code_q;
    entry_d = commit ? (acc ? {{(ENTRY_W-NIBBLE_W){1'b0}}, key_code_d} : '0)
            : acc ? {entry_q[ENTRY_W-NIBBLE_W-1:0], key_code_d} : entry_q;
    value_out_d = commit ? entry_q : value_out_q;
    value_valid_d = commit | (value_valid_q & ~value_ready);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      en_s1_q <= 1'b0;
      en_s2_q <= 1'b0;
      en_prev_q <= 1'b0;
      st_q <= SCAN;
      row_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
      key_valid_q <= 1'b0;
      key_code_q <= '0;
      entry_q <= '0;
      value_out_q <= '0;
      value_valid_q <= 1'b0;
    end else begin
      row_s1_q <= row_in;
      row_s2_q <= row_s1_q;
      en_s1_q <= enter;
      en_s2_q <= en_s1_q;
      en_prev_q <= en_s2_q;
      st_q <= st_d;
      row_q <= row_d;
      col_q <= col_d;
      cnt_q <= cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q <= key_code_d;
      entry_q <= entry_d;
      value_out_q <= value_out_d;
      value_valid_q <= value_valid_d;
    end
  end
  assign key_valid = key_valid_q;
  assign key_code = key_code_q;
  assign entry = entry_q;
  assign value_out = value_out_q;
  assign value_valid = value_valid_q;
endmodule
